fp_packer: RTL and testbench

//  Packs an unpacked FP operand (sign, biased exponent, 53-bit significand with explicit

---
 rtl/fp_packer.sv | 157 +++++++++++++++
 tb/tb_fp_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_packer.sv
// Packs an unpacked FP operand into IEEE-754 double or single format.
// Tiny results are denormalised by a one-bit-per-clock right shifter with sticky tracking.
module fp_packer #(
  parameter int unsigned N         = 64,
  parameter int unsigned MAX_SHIFT = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         dbs,
  input  logic         s,
  input  logic [12:0]  e,
  input  logic [52:0]  f,
  input  logic         nan,
  input  logic         inf,
  input  logic         zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         ovf,
  output logic         unf,
  output logic         inexact
);

  localparam int unsigned CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e         state_q, state_d;
  logic           s_q, dbs_q, sticky_q;
  logic [52:0]    f_q;
  logic [CW-1:0]  cnt_q;
  logic [63:0]    y_q;
  logic           ovf_q, unf_q, inexact_q;

  logic           accept, is_denorm, shift_last;
  logic [63:0]    acc_y;
  logic           acc_ovf, acc_inexact;
  logic [CW-1:0]  acc_cnt;
  logic [52:0]    f_sh;
  logic           sticky_sh;
  logic [63:0]    dn_y;
  logic           dn_inexact;
  int             e_int, k_int;

  // Classification and packing of the operand presented at the input.
  always_comb begin
    e_int       = int'($signed(e));
    k_int       = 1 - e_int;
    is_denorm   = !nan && !inf && !zero && (f != '0) && (e_int < 1);
    acc_cnt     = (k_int > int'(MAX_SHIFT)) ? CW'(MAX_SHIFT) : CW'(k_int);
    acc_y       = '0;
    acc_ovf     = 1'b0;
    acc_inexact = 1'b0;
    if (nan) begin
      acc_y = dbs ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    end else if (inf) begin
      acc_y = dbs ? {s, 11'h7FF, 52'h0} : {32'h0, s, 8'hFF, 23'h0};
    end else if (zero || (f == '0)) begin
      acc_y = dbs ? {s, 63'h0} : {32'h0, s, 31'h0};
    end else if (e_int > (dbs ? 2046 : 254)) begin
      acc_y       = dbs ? {s, 11'h7FF, 52'h0} : {32'h0, s, 8'hFF, 23'h0};
      acc_ovf     = 1'b1;
      acc_inexact = 1'b1;
    end else if (dbs) begin
      acc_y = {s, e[10:0], f[51:0]};
    end else begin
      acc_y       = {32'h0, s, e[7:0], f[51:29]};
      acc_inexact = |f[28:0];
    end
  end

  // Shifter step and packing of the value it produces on its last step.
  always_comb begin
    f_sh       = {1'b0, f_q[52:1]};
    sticky_sh  = sticky_q | f_q[0];
    shift_last = (cnt_q == CW'(1));
    if (dbs_q) begin
      dn_y       = {s_q, 11'h0, f_sh[51:0]};
      dn_inexact = sticky_sh;
    end else begin
      dn_y       = {32'h0, s_q, 8'h0, f_sh[51:29]};
      dn_inexact = sticky_sh | (|f_sh[28:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = is_denorm ? StShift : StDone;
      StShift: if (shift_last) state_d = StDone;
      StDone: begin
        if (accept)         state_d = is_denorm ? StShift : StDone;
        else if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = (state_q == StDone);
    in_ready  = !rst && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    accept    = in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= 1'b0;
      dbs_q     <= 1'b0;
      f_q       <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else if (accept) begin
      s_q      <= s;
      dbs_q    <= dbs;
      f_q      <= f;
      sticky_q <= 1'b0;
      cnt_q    <= acc_cnt;
      // Denormal results are written when the shifter finishes.
      if (!is_denorm) begin
        y_q       <= acc_y;
        ovf_q     <= acc_ovf;
        unf_q     <= 1'b0;
        inexact_q <= acc_inexact;
      end
    end else if (state_q == StShift) begin
      f_q      <= f_sh;
      sticky_q <= sticky_sh;
      cnt_q    <= cnt_q - CW'(1);
      if (shift_last) begin
        y_q       <= dn_y;
        ovf_q     <= 1'b0;
        unf_q     <= 1'b1;
        inexact_q <= dn_inexact;
      end
    end
  end

  assign y       = y_q[N-1:0];
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_fp_packer.sv
// Self-checking bench for fp_packer: directed cases, randomized operands against a
// behavioural model, stall/back-to-back handshake and reset during a denormal shift.
module tb_fp_packer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, dbs, s, nan, inf, zero;
  logic        out_valid, out_ready, ovf, unf, inexact;
  logic [12:0] e;
  logic [52:0] f;
  logic [63:0] y;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_packer #(.N(64), .MAX_SHIFT(55)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dbs      (dbs),
    .s        (s),
    .e        (e),
    .f        (f),
    .nan      (nan),
    .inf      (inf),
    .zero     (zero),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .ovf      (ovf),
    .unf      (unf),
    .inexact  (inexact)
  );

  // Reference: flags are {ovf, unf, inexact}; latency counted in clocks after accept.
  task automatic model(input logic m_dbs, input logic m_s, input logic [12:0] m_e,
                       input logic [52:0] m_f, input logic m_nan, input logic m_inf,
                       input logic m_zero, output logic [63:0] m_y,
                       output logic [2:0] m_fl, output int m_lat);
    int          ei, emax, k;
    logic [63:0] mant, lost;
    logic [12:0] expf;
    ei    = int'($signed(m_e));
    emax  = m_dbs ? 2046 : 254;
    m_lat = 1;
    m_fl  = 3'b000;
    if (m_nan) begin
      m_y = m_dbs ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    end else if (m_inf) begin
      m_y = m_dbs ? {m_s, 11'h7FF, 52'h0} : {32'h0, m_s, 8'hFF, 23'h0};
    end else if (m_zero || m_f == 53'h0) begin
      m_y = m_dbs ? {m_s, 63'h0} : {32'h0, m_s, 31'h0};
    end else if (ei > emax) begin
      m_y  = m_dbs ? {m_s, 11'h7FF, 52'h0} : {32'h0, m_s, 8'hFF, 23'h0};
      m_fl = 3'b101;
    end else begin
      mant = {11'h0, m_f};
      expf = m_e;
      if (ei < 1) begin
        k     = 1 - ei;
        if (k > 55) k = 55;
        m_lat = k + 1;
        lost  = mant & ((64'h1 << k) - 64'h1);
        mant  = mant >> k;
        expf  = 13'h0;
        m_fl  = {1'b0, 1'b1, lost != 64'h0};
      end
      if (m_dbs) begin
        m_y = {m_s, expf[10:0], mant[51:0]};
      end else begin
        m_y     = {32'h0, m_s, expf[7:0], mant[51:29]};
        m_fl[0] = m_fl[0] | (mant[28:0] != 29'h0);
      end
    end
  endtask

  // Presents one operand, scrambles inputs after accept, waits (bounded) for out_valid.
  // Leaves the result pending; o_lat = -1 when no result appears.
  task automatic run_op(input logic i_dbs, input logic i_s, input logic [12:0] i_e,
                        input logic [52:0] i_f, input logic i_nan, input logic i_inf,
                        input logic i_zero, output logic [63:0] o_y,
                        output logic [2:0] o_fl, output int o_lat);
    int waitc = 0;
    dbs = i_dbs; s = i_s; e = i_e; f = i_f; nan = i_nan; inf = i_inf; zero = i_zero;
    in_valid = 1'b1;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = 13'($urandom); f = 53'($urandom); s = ~s; dbs = ~dbs;
    o_lat = 1;
    while (!out_valid && o_lat < 100) begin
      @(posedge clk); #1; o_lat++;
    end
    if (!out_valid) o_lat = -1;
    o_y  = y;
    o_fl = {ovf, unf, inexact};
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || y !== 64'h0 ||
        {ovf, unf, inexact} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b y=%h flags=%b, want 0/0/0/000",
               out_valid, in_ready, y, {ovf, unf, inexact});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic        td [5], ts [5], tn [5];
    logic [12:0] te [5];
    logic [52:0] tf [5];
    logic [63:0] ty [5];
    logic [2:0]  tfl [5];
    int          tl [5];
    logic [63:0] oy;
    logic [2:0]  ofl;
    int          olat;
    td = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    te = '{13'd1023, 13'd127, 13'h1FFF, 13'd2047, 13'd2047};
    tf = '{53'h10000000000000, 53'h18000000000000, 53'h10000000000000,
           53'h10000000000000, 53'h10000000000000};
    ty = '{64'h3FF0000000000000, 64'h00000000BFC00000, 64'h0004000000000000,
           64'h7FF0000000000000, 64'h7FF8000000000000};
    tfl = '{3'b000, 3'b000, 3'b010, 3'b101, 3'b000};
    tl = '{1, 1, 3, 1, 1};
    for (int i = 0; i < 5; i++) begin
      run_op(td[i], ts[i], te[i], tf[i], tn[i], 1'b0, 1'b0, oy, ofl, olat);
      checks++;
      if (oy !== ty[i] || ofl !== tfl[i] || olat != tl[i]) begin
        failures++;
        $display("FAIL directed_%0d: y=%h flags=%b lat=%0d, want y=%h flags=%b lat=%0d",
                 i, oy, ofl, olat, ty[i], tfl[i], tl[i]);
      end
      drain();
    end
  endtask

  task automatic test_random();
    logic        rd, rs, rn, ri, rz;
    logic [12:0] re;
    logic [52:0] rf;
    logic [63:0] tmp, my, oy;
    logic [2:0]  mfl, ofl;
    int          mlat, olat, emax;
    for (int i = 0; i < 60; i++) begin
      rd  = 1'($urandom); rs = 1'($urandom);
      tmp = {$urandom, $urandom};
      rf  = tmp[52:0];
      rf[52] = 1'b1;
      rn = 1'b0; ri = 1'b0; rz = 1'b0;
      emax = rd ? 2046 : 254;
      case ($urandom_range(0, 7))
        0, 1, 2: re = 13'($urandom_range(1, emax));
        3, 4:    re = 13'(1 - int'($urandom_range(1, 62)));
        5:       re = 13'(emax + int'($urandom_range(1, 200)));
        6: begin
          re = 13'($urandom);
          case ($urandom_range(0, 3))
            0: rn = 1'b1;
            1: ri = 1'b1;
            2: rz = 1'b1;
            default: rf = 53'h0;
          endcase
        end
        default: re = 13'($urandom);
      endcase
      model(rd, rs, re, rf, rn, ri, rz, my, mfl, mlat);
      run_op(rd, rs, re, rf, rn, ri, rz, oy, ofl, olat);
      checks++;
      if (oy !== my || ofl !== mfl || olat != mlat) begin
        failures++;
        $display("FAIL random_%0d (dbs=%b e=%0d f=%h): y=%h flags=%b lat=%0d, want %h %b %0d",
                 i, rd, $signed(re), rf, oy, ofl, olat, my, mfl, mlat);
      end
      drain();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_drained: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] oy;
    logic [2:0]  ofl;
    int          olat;
    run_op(1'b1, 1'b0, 13'd1023, 53'h10000000000000, 1'b0, 1'b0, 1'b0, oy, ofl, olat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || y !== 64'h3FF0000000000000 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d: out_valid=%b y=%h in_ready=%b, want 1 3ff0000000000000 0",
                 i, out_valid, y, in_ready);
      end
    end
    dbs = 1'b0; s = 1'b1; e = 13'd127; f = 53'h18000000000000;
    nan = 1'b0; inf = 1'b0; zero = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || y !== 64'h00000000BFC00000 || {ovf, unf, inexact} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_result: out_valid=%b y=%h flags=%b, want 1 00000000bfc00000 000",
               out_valid, y, {ovf, unf, inexact});
    end
    drain();
  endtask

  task automatic test_reset_mid_shift();
    int          seen = 0;
    logic [63:0] oy;
    logic [2:0]  ofl;
    int          olat;
    dbs = 1'b1; s = 1'b0; e = 13'(-40); f = 53'h1ABCDEF0123456;
    nan = 1'b0; inf = 1'b0; zero = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_shift: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_no_output: results=%0d in_ready=%b, want 0 results in_ready=1",
               seen, in_ready);
    end
    run_op(1'b1, 1'b1, 13'h1FFF, 53'h10000000000001, 1'b0, 1'b0, 1'b0, oy, ofl, olat);
    checks++;
    if (oy !== 64'h8004000000000000 || ofl !== 3'b011 || olat != 3) begin
      failures++;
      $display("FAIL rst_recover: y=%h flags=%b lat=%0d, want 8004000000000000 011 3",
               oy, ofl, olat);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dbs = 1'b0; s = 1'b0; e = 13'h0; f = 53'h0; nan = 1'b0; inf = 1'b0; zero = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
